control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  - Sequencer for the 4x4 4-bit image-convolution datapath. A 4-bit state counter G is
//    decoded into 16 one-hot timing signals T[15:0] that gate the datapath micro-operations.
//  - E starts (and, optionally, sustains) a run. Q is a datapath status flag that decides
//    whether the window loop repeats or the sequence proceeds.
// PARAMETERS
//  - BRANCH_STATE  7  State index that tests Q. Legal range 1..14.
//  - LOOP_STATE    2  State index entered when Q=0 in BRANCH_STATE. Legal range 1..BRANCH_STATE.
// PORTS
//  - clk    in   1   Clock. Only clock; all state updates on the rising edge.
//  - reset  in   1   Synchronous, active-low reset (0 = reset).
//  - E      in   1   Enable/start.
//  - Q      in   1   Loop-condition flag from the datapath.
//  - T      out  16  One-hot timing signals. T[k]=1 iff G==k.
// BEHAVIOUR
//  - State: G[3:0] register. T = 16'h0001 << G, decoded combinationally from G.
//    No other logic feeds T.
//  - T is exactly one-hot at all times. There is no all-zero state and no X after reset.
//  - Reset: if reset==0 at a posedge, G<=0, so T=16'h0001 from that edge on. Reset overrides
//    E/Q. It has the same effect mid-run as from idle.
//  - Transitions at each posedge with reset==1:
//      - G==0 (idle):
//          - E=1 -> G=1
//          - E=0 -> stay at 0
//      - G==BRANCH_STATE:
//          - Q=1 -> G=BRANCH_STATE+1
//          - Q=0 -> G=LOOP_STATE
//      - G==15 -> G=0, unconditionally (run complete). Sampling E in T0 allows back-to-back runs.
//      - any other G (1..14) -> G+1.
//  - Q is sampled only in BRANCH_STATE. E is sampled only in T0, except when CU_STALL_EN is defined.
//  - Latency: input sampled at edge n takes effect in T after edge n. T has no extra output register.
//  - With E=Q=1 held, T walks T0->T15->T0 with a period of 16 clocks.
//  - Counter arithmetic is 4-bit. 15->0 is the only wrap, and it is explicit.
//  - Unused/illegal parameter combinations are not supported. Add an elaboration-time check
//    that errors if BRANCH_STATE is outside 1..14 or LOOP_STATE is outside 1..BRANCH_STATE.
// CONFIGURATION
//  - CU_STALL_EN defined:
//      - In states 1..15, E=0 holds G (stall). This includes BRANCH_STATE, where Q is ignored
//        while stalled, and T15, which waits.
//      - E=1 applies the normal transition.
//  - CU_STALL_EN undefined: E is ignored outside T0. Once started, a run always completes.
//  - Reset behaviour is identical in both builds.
// TESTING
//  - Reset low for 1 posedge, E=Q=0 -> T==16'h0001. Release reset, E=0 for 5 clocks -> T stays 16'h0001.
//  - reset=1, E=Q=1 held -> T: 0002,0004,...,8000, then 0001,0002 on successive edges
//    (period 16, one-hot checked every cycle).
//  - Defaults, run to T7 (T==16'h0080):
//      - Q=0 -> next T==16'h0004.
//      - Rerun to T7 with Q=1 -> next T==16'h0100.
//  - Mid-run at T==16'h0040, drive reset=0 for one edge -> T==16'h0001. With E=1 after release -> T==16'h0002.
//  - CU_STALL_EN defined:
//      - At T5, drive E=0 for 3 clocks -> T holds 16'h0020. E=1 -> 16'h0040.
//      - Same stimulus without the macro -> 16'h0040, 0080, 0100 (no stall).
//  - Parameter sweep BRANCH_STATE=14, LOOP_STATE=1:
//      - Q=0 at T14 -> next T==16'h0002.
//      - Q=1 at T14 -> next 16'h8000, then 16'h0001.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: sequencer for the 4x4 4-bit image-convolution datapath.
//
// A 4-bit state counter G steps through the convolution sequence. G is decoded
// combinationally into 16 one-hot timing signals T[15:0] that gate the datapath
// micro-operations.
//
// Parameters:
//   BRANCH_STATE  state that tests Q (legal 1..14)
//   LOOP_STATE    state re-entered when Q=0 in BRANCH_STATE (legal 1..BRANCH_STATE)
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-low reset (0 = reset)
//   E      in   1   enable/start, sampled in T0 (and in every state when stalling is built in)
//   Q      in   1   loop-condition flag from the datapath, sampled in BRANCH_STATE
//   T      out  16  one-hot timing signals, T[k] = 1 iff G == k
//
// Build option:
//   CU_STALL_EN  when defined, E=0 in states 1..15 holds G (the run stalls).
//                When undefined, E is ignored outside T0 and a started run always completes.
module control_unit #(
    parameter int unsigned BRANCH_STATE = 7,
    parameter int unsigned LOOP_STATE   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E,
    input  logic        Q,
    output logic [15:0] T
);

    // Reject unsupported parameter combinations at elaboration.
    if (BRANCH_STATE < 1 || BRANCH_STATE > 14) begin : gen_bad_branch
        $error("control_unit: BRANCH_STATE must be in 1..14");
    end
    if (LOOP_STATE < 1 || LOOP_STATE > BRANCH_STATE) begin : gen_bad_loop
        $error("control_unit: LOOP_STATE must be in 1..BRANCH_STATE");
    end

    localparam logic [3:0] BranchIdx = 4'(BRANCH_STATE);
    localparam logic [3:0] BranchNxt = 4'(BRANCH_STATE + 1);
    localparam logic [3:0] LoopIdx   = 4'(LOOP_STATE);
    localparam logic [3:0] IdleIdx   = 4'd0;
    localparam logic [3:0] LastIdx   = 4'd15;

    logic [3:0] g_q;
    logic [3:0] g_d;
    logic       advance;

    // Whether a non-idle state may move on this cycle.
`ifdef CU_STALL_EN
    assign advance = E;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        g_d = g_q;
        if (g_q == IdleIdx) begin
            if (E) begin
                g_d = 4'd1;
            end
        end else if (advance) begin
            if (g_q == LastIdx) begin
                // Explicit wrap: the only place the counter returns to idle.
                g_d = IdleIdx;
            end else if (g_q == BranchIdx) begin
                g_d = Q ? BranchNxt : LoopIdx;
            end else begin
                g_d = g_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            g_q <= IdleIdx;
        end else begin
            g_q <= g_d;
        end
    end

    // Pure decode of the state register; nothing else drives T.
    assign T = 16'h0001 << g_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        E;
    logic        Q;
    logic [15:0] t_a;
    logic [15:0] t_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: plain step indices per instance.
    int  sa = 0;
    int  sb = 0;
    bit  valid = 1'b0;

    always #5 clk = ~clk;

    control_unit u_dut_a (
        .clk   (clk),
        .reset (reset),
        .E     (E),
        .Q     (Q),
        .T     (t_a)
    );

    control_unit #(
        .BRANCH_STATE (14),
        .LOOP_STATE   (1)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .E     (E),
        .Q     (Q),
        .T     (t_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_next(input int s, input bit e, input bit q,
                                    input int branch, input int loop_to);
        if (s == 0) return e ? 1 : 0;
`ifdef CU_STALL_EN
        if (!e) return s;
`endif
        if (s == 15) return 0;
        if (s == branch) return q ? branch + 1 : loop_to;
        return s + 1;
    endfunction

    function automatic logic [15:0] onehot(input int s);
        logic [15:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // One clock: advance the models on the edge, then compare both DUTs.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            sa = 0;
            sb = 0;
            valid = 1'b1;
        end else begin
            sa = ref_next(sa, E, Q, 7, 2);
            sb = ref_next(sb, E, Q, 14, 1);
        end
        #1;
        if (valid) begin
            check("model_a", t_a, onehot(sa));
            check("model_b", t_b, onehot(sb));
            check("onehot_a", 16'($countones(t_a)), 16'd1);
            check("onehot_b", 16'($countones(t_b)), 16'd1);
        end
    endtask

    task automatic run_to_a(input int target);
        E = 1'b1;
        Q = 1'b1;
        for (int i = 0; i < 40 && sa != target; i++) step();
        check("reach_a", 16'(sa), 16'(target));
    endtask

    task automatic run_to_b(input int target);
        E = 1'b1;
        Q = 1'b1;
        for (int i = 0; i < 40 && sb != target; i++) step();
        check("reach_b", 16'(sb), 16'(target));
    endtask

    initial begin
        reset = 1'b0;
        E = 1'b0;
        Q = 1'b0;
        step();
        check("reset_a", t_a, 16'h0001);
        check("reset_b", t_b, 16'h0001);

        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_hold", t_a, 16'h0001);
        end

        // Full walk with E=Q=1: period 16.
        E = 1'b1;
        Q = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("walk", t_a, 16'h0001 << (k % 16));
        end

        // Branch with Q=0 loops back.
        run_to_a(7);
        check("at_t7", t_a, 16'h0080);
        Q = 1'b0;
        step();
        check("branch_q0", t_a, 16'h0004);
        run_to_a(7);
        Q = 1'b1;
        step();
        check("branch_q1", t_a, 16'h0100);

        // Mid-run reset.
        run_to_a(0);
        run_to_a(6);
        check("at_t6", t_a, 16'h0040);
        reset = 1'b0;
        step();
        check("midrun_reset", t_a, 16'h0001);
        reset = 1'b1;
        E = 1'b1;
        step();
        check("restart", t_a, 16'h0002);

        // Stall behaviour at T5.
        run_to_a(5);
        E = 1'b0;
        step();
`ifdef CU_STALL_EN
        check("stall_0", t_a, 16'h0020);
        step();
        check("stall_1", t_a, 16'h0020);
        step();
        check("stall_2", t_a, 16'h0020);
        E = 1'b1;
        step();
        check("stall_go", t_a, 16'h0040);
`else
        check("nostall_0", t_a, 16'h0040);
        step();
        check("nostall_1", t_a, 16'h0080);
        step();
        check("nostall_2", t_a, 16'h0100);
`endif

        // Second instance: BRANCH_STATE=14, LOOP_STATE=1.
        run_to_b(14);
        check("b_at_t14", t_b, 16'h4000);
        E = 1'b1;
        Q = 1'b0;
        step();
        check("b_branch_q0", t_b, 16'h0002);
        run_to_b(14);
        E = 1'b1;
        Q = 1'b1;
        step();
        check("b_branch_q1", t_b, 16'h8000);
        step();
        check("b_wrap", t_b, 16'h0001);

        // Randomized traffic against the models.
        for (int i = 0; i < 2000; i++) begin
            E = ($urandom_range(0, 3) != 0);
            Q = $urandom_range(0, 1) == 1;
            reset = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
